// File: rtl/bnn_seq_engine.sv
// ---------------------------------------------------------------------------
// bnn_seq_engine
// Two-layer (N_IN -> N_HID -> 1) step-activation perceptron with run-time
// loadable signed weights and biases. One multiply-accumulate term is folded
// into a saturating accumulator per clock by a small FSM:
//   IDLE -> HID (N_HID*N_IN cycles) -> OUT (N_HID cycles) -> DONE -> IDLE.
// DONE spends one cycle settling before out_valid rises. This gives
// N_HID*N_IN + N_HID + 1 cycles from the accept edge to out_valid.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   in_valid/in_ready/x   binary input vector handshake
//   out_valid/out_ready   result handshake; out = network bit,
//   out, hid, ovf         hid = hidden activations (bit h = neuron h),
//                         ovf = saturation seen in the last inference
//   busy                  FSM not in IDLE
//   cfg_we/addr/data      parameter write port (IDLE or DONE only)
//   cfg_err               one-cycle pulse when a write is dropped
// Parameter map: w(h,i) @ h*N_IN+i, wo(h) @ N_HID*N_IN+h,
//                hb(h) @ N_HID*N_IN+N_HID+h, output bias @ last address.
// ---------------------------------------------------------------------------
module bnn_seq_engine #(
    parameter int N_IN  = 2,
    parameter int N_HID = 2,
    parameter int W     = 16,
    parameter int ACC_W = 24,
    localparam int AW   = $clog2(N_HID * N_IN + 2 * N_HID + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN-1:0]     x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out,
    output logic [N_HID-1:0]    hid,
    output logic                ovf,
    output logic                busy,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic signed [W-1:0] cfg_data,
    output logic                cfg_err
);
    localparam int NHI = N_HID * N_IN;
    localparam int NE  = NHI + 2 * N_HID + 1;
    localparam int HB0 = NHI + N_HID;
    localparam int SW  = ACC_W + 1;
    localparam int HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HID  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Saturating signed add; returns {saturated, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [W-1:0] b);
        logic signed [SW-1:0] wide;
        logic [ACC_W:0]       res;
        wide = SW'(a) + SW'(b);
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            if (wide[ACC_W]) begin
                res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            res = {1'b0, wide[ACC_W-1:0]};
        end
        return res;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic signed [W-1:0]     prm_r [NE];
    logic [N_IN-1:0]         x_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [HW-1:0]           h_r;
    logic [IW-1:0]           i_r;
    logic [N_HID-1:0]        hid_r;
    logic                    out_r, ovf_r, out_valid_r, in_ready_r, busy_r, cfg_err_r;

    logic                    accept_s, cfg_ok_s, last_i_s, last_h_s, gate_s, sat_s;
    logic [AW-1:0]           op_idx_s, bias_idx_s;
    logic signed [W-1:0]     term_s, hb0_s;
    logic [ACC_W:0]          add_s;
    logic signed [ACC_W-1:0] sum_s;

    // Operand selection, saturating sum and config-write qualification
    always_comb begin
        accept_s   = (state_r == S_IDLE) && in_valid;
        cfg_ok_s   = cfg_we && ((state_r == S_IDLE) || (state_r == S_DONE))
                     && (int'(cfg_addr) < NE);
        last_i_s   = (int'(i_r) == N_IN - 1);
        last_h_s   = (int'(h_r) == N_HID - 1);
        // Output bias sits right after the last hidden bias, so h+1 covers both cases.
        bias_idx_s = AW'(HB0 + 1 + int'(h_r));
        if (state_r == S_OUT) begin
            op_idx_s = AW'(NHI + int'(h_r));
            gate_s   = hid_r[h_r];
        end else begin
            op_idx_s = AW'(int'(h_r) * N_IN + int'(i_r));
            gate_s   = x_r[i_r];
        end
        if (gate_s) begin
            term_s = prm_r[op_idx_s];
        end else begin
            term_s = {W{1'b0}};
        end
        add_s = sat_add(acc_r, term_s);
        sat_s = add_s[ACC_W];
        sum_s = add_s[ACC_W-1:0];
        // A write to hidden bias 0 on the accept edge must reach this inference.
        if (cfg_ok_s && (int'(cfg_addr) == HB0)) begin
            hb0_s = cfg_data;
        end else begin
            hb0_s = prm_r[HB0];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_HID;
                else          state_nxt_s = S_IDLE;
            end
            S_HID: begin
                if (last_i_s && last_h_s) state_nxt_s = S_OUT;
                else                      state_nxt_s = S_HID;
            end
            S_OUT: begin
                if (last_h_s) state_nxt_s = S_DONE;
                else          state_nxt_s = S_OUT;
            end
            S_DONE: begin
                if (out_valid_r && out_ready) state_nxt_s = S_IDLE;
                else                          state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_r <= S_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Parameter file, accumulator, counters and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < NE; k++) prm_r[k] <= {W{1'b0}};
            x_r         <= {N_IN{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            h_r         <= {HW{1'b0}};
            i_r         <= {IW{1'b0}};
            hid_r       <= {N_HID{1'b0}};
            out_r       <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r  <= cfg_we && !cfg_ok_s;
            if (cfg_ok_s) prm_r[cfg_addr] <= cfg_data;
            in_ready_r <= (state_nxt_s == S_IDLE);
            busy_r     <= (state_nxt_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        x_r   <= x;
                        ovf_r <= 1'b0;
                        acc_r <= ACC_W'(hb0_s);
                        h_r   <= {HW{1'b0}};
                        i_r   <= {IW{1'b0}};
                    end
                end
                S_HID: begin
                    ovf_r <= ovf_r | sat_s;
                    if (last_i_s) begin
                        hid_r[h_r] <= ~sum_s[ACC_W-1];
                        acc_r      <= ACC_W'(prm_r[bias_idx_s]);
                        i_r        <= {IW{1'b0}};
                        if (last_h_s) h_r <= {HW{1'b0}};
                        else          h_r <= h_r + HW'(1);
                    end else begin
                        acc_r <= sum_s;
                        i_r   <= i_r + IW'(1);
                    end
                end
                S_OUT: begin
                    ovf_r <= ovf_r | sat_s;
                    acc_r <= sum_s;
                    if (last_h_s) out_r <= ~sum_s[ACC_W-1];
                    else          h_r   <= h_r + HW'(1);
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid; the handshake drops it.
                    if (!out_valid_r)   out_valid_r <= 1'b1;
                    else if (out_ready) out_valid_r <= 1'b0;
                    else                out_valid_r <= 1'b1;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign hid       = hid_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule
